one_four_demux: RTL and testbench

ONE_FOUR_DEMUX -- requirements
Module: one_four_demux

---
 rtl/one_four_demux_pkg.sv | 16 +
 rtl/one_four_demux_slot.sv | 45 ++++
 rtl/one_four_demux.sv | 81 ++++++++
 tb/tb_one_four_demux.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/one_four_demux_pkg.sv
// Shared constants for the one-to-four demux: channel count, select width, counter width.
package one_four_demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/one_four_demux_slot.sv
// One-entry holding register for a single demux channel (data word plus valid flag).
module demux_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    // A load in the same cycle as a drain wins: the slot stays full with the new word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/one_four_demux.sv
// Routes a valid/ready input stream to one of four single-entry output channels
// and counts accepted words.
module one_four_demux
    import one_four_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data0,
    output logic [WIDTH-1:0]   out_data1,
    output logic [WIDTH-1:0]   out_data2,
    output logic [WIDTH-1:0]   out_data3,
    output logic [NUM_CH-1:0]  out_valid,
    input  logic [NUM_CH-1:0]  out_ready,
    output logic [CNT_W-1:0]   accept_count
);

    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] slot_load;
    logic [NUM_CH-1:0] slot_drain;
    logic [WIDTH-1:0]  slot_q [NUM_CH];
    logic              accept;

    logic [CNT_W-1:0]  accept_count_q;
    logic [CNT_W-1:0]  accept_count_d;

    // Ready when the target slot is empty or is being drained this cycle.
    assign in_ready = (~slot_valid[in_sel] | out_ready[in_sel]) & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        slot_load  = '0;
        slot_drain = slot_valid & out_ready;
        if (accept) begin
            slot_load = sel_onehot(in_sel);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (slot_load[k]),
            .drain (slot_drain[k]),
            .d     (in_data),
            .q     (slot_q[k]),
            .valid (slot_valid[k])
        );
    end

    // Free-running accept counter; wraps naturally at 2^CNT_W.
    always_comb begin
        accept_count_d = accept_count_q;
        if (accept) begin
            accept_count_d = accept_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accept_count_q <= '0;
        end else begin
            accept_count_q <= accept_count_d;
        end
    end

    assign out_valid    = slot_valid;
    assign out_data0    = slot_q[0];
    assign out_data1    = slot_q[1];
    assign out_data2    = slot_q[2];
    assign out_data3    = slot_q[3];
    assign accept_count = accept_count_q;

endmodule

// File: tb/tb_one_four_demux.sv
// Directed self-checking bench for one_four_demux.
module tb_one_four_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data0;
    logic [7:0] out_data1;
    logic [7:0] out_data2;
    logic [7:0] out_data3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] accept_count;

    int checks = 0;
    int errors = 0;

    one_four_demux #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_sel       (in_sel),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data0    (out_data0),
        .out_data1    (out_data1),
        .out_data2    (out_data2),
        .out_data3    (out_data3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 8'hFF;
        out_ready = 4'b0000;

        // Reset held three cycles with a word on offer.
        tick(); tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_data0", 32'(out_data0), 32'h0);
        check("rst_data1", 32'(out_data1), 32'h0);
        check("rst_data2", 32'(out_data2), 32'h0);
        check("rst_data3", 32'(out_data3), 32'h0);
        check("rst_count", 32'(accept_count), 32'h0);

        // Basic routing to channel 2.
        rst      = 1'b0;
        in_sel   = 2'd2;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        #1;
        check("basic_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("basic_valid", 32'(out_valid), 32'b0100);
        check("basic_data2", 32'(out_data2), 32'hA5);
        check("basic_count", 32'(accept_count), 32'd1);

        // Backpressure: channel 2 full and stalled.
        in_data = 8'h3C;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("bp_hold_data2", 32'(out_data2), 32'hA5);
        check("bp_hold_valid", 32'(out_valid), 32'b0100);
        check("bp_hold_count", 32'(accept_count), 32'd1);
        out_ready = 4'b0100;
        #1;
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        tick();
        check("bp_replace_data2", 32'(out_data2), 32'h3C);
        check("bp_replace_valid", 32'(out_valid), 32'b0100);
        check("bp_replace_count", 32'(accept_count), 32'd2);

        // Independence: channel 2 stalled, word to channel 0.
        out_ready = 4'b0000;
        in_sel    = 2'd0;
        in_data   = 8'h11;
        #1;
        check("ind_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("ind_valid", 32'(out_valid), 32'b0101);
        check("ind_data0", 32'(out_data0), 32'h11);
        check("ind_data2", 32'(out_data2), 32'h3C);
        check("ind_count", 32'(accept_count), 32'd3);

        // No accept: in_sel/in_data ignored.
        in_valid = 1'b0;
        in_sel   = 2'd1;
        in_data  = 8'h77;
        tick();
        check("idle_valid", 32'(out_valid), 32'b0101);
        check("idle_data1", 32'(out_data1), 32'h0);
        check("idle_count", 32'(accept_count), 32'd3);

        // Drain all; data stays at last value.
        out_ready = 4'b1111;
        tick();
        check("drain_valid", 32'(out_valid), 32'b0000);
        check("drain_data0", 32'(out_data0), 32'h11);
        check("drain_data2", 32'(out_data2), 32'h3C);

        // Counter wrap: 253 more accepts take 3 -> 255 -> 0.
        for (int j = 0; j < 253; j++) begin
            in_sel   = 2'(j);
            in_data  = 8'(j + 1);
            in_valid = 1'b1;
            #1;
            check("wrap_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (j == 251) check("wrap_count_255", 32'(accept_count), 32'd255);
        end
        check("wrap_count_0", 32'(accept_count), 32'd0);
        check("wrap_last_data0", 32'(out_data0), 32'hFD);
        check("wrap_last_valid", 32'(out_valid), 32'b0001);
        in_valid = 1'b0;
        tick();
        check("wrap_drained", 32'(out_valid), 32'b0000);

        // Mid-operation reset with channels 1 and 3 full.
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 8'h21;
        tick();
        in_sel  = 2'd3;
        in_data = 8'h43;
        tick();
        check("mid_fill_valid", 32'(out_valid), 32'b1010);
        check("mid_fill_count", 32'(accept_count), 32'd2);
        rst     = 1'b1;
        in_data = 8'h99;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'b0000);
        check("mid_rst_data1", 32'(out_data1), 32'h0);
        check("mid_rst_data3", 32'(out_data3), 32'h0);
        check("mid_rst_count", 32'(accept_count), 32'd0);
        rst     = 1'b0;
        in_data = 8'h5A;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'b1000);
        check("post_rst_data3", 32'(out_data3), 32'h5A);
        check("post_rst_count", 32'(accept_count), 32'd1);

        in_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
